// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi4_lite_pkg
// Purpose : Shared AXI4-Lite response codes and FSM state encodings for the
//           axi4_lite_master_ex bus master.
// Revision: 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module  : axi_timeout_ctr
// Purpose : Busy-cycle counter that flags when a channel has been non-idle
//           for LIMIT cycles. Only instantiated when AXI_TIMEOUT_EN is defined.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_clear       - hold count at zero (channel idle)
//           i_enable      - count this cycle (channel busy)
//           o_expired     - this is the LIMIT-th busy cycle; abort now
// Revision: 1.0 - initial release
// ============================================================================
module axi_timeout_ctr #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // Flag on the cycle in which the count would reach LIMIT so the owning
  // FSM aborts on that same edge.
  assign o_expired = i_enable && (r_cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_master_ex.sv
`default_nettype none
// ============================================================================
// Module  : axi4_lite_master_ex
// Purpose : Single-beat AXI4-Lite master with independent write and read
//           channels, user byte strobes, latched responses and done pulses.
// Ports   : M_AXI_ACLK / M_AXI_ARESET - clock, synchronous active-high reset
//           AMCI_W*  - user write request (address, data, strobes, start)
//                      and status (idle, done pulse, response, timeout)
//           AMCI_R*  - user read request (address, start) and status
//                      (idle, done pulse, data, response, timeout)
//           M_AXI_*  - AXI4-Lite master channels AW, W, B, AR, R
// Options : define AXI_TIMEOUT_EN to abort transactions that stay busy for
//           C_TIMEOUT_CYCLES cycles (DECERR + timeout flag).
// Revision: 1.0 - initial release
// ============================================================================
module axi4_lite_master_ex
  import axi4_lite_pkg::*;
#(
  parameter int         C_AXI_DATA_WIDTH = 32,
  parameter int         C_AXI_ADDR_WIDTH = 32,
  parameter logic [2:0] C_AWPROT         = 3'b000,
  parameter logic [2:0] C_ARPROT         = 3'b001,
  parameter int         C_TIMEOUT_CYCLES = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  // user write side
  input  logic [C_AXI_ADDR_WIDTH-1:0]     AMCI_WADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]     AMCI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   AMCI_WSTRB,
  input  logic                            AMCI_WRITE,
  output logic                            AMCI_WIDLE,
  output logic                            AMCI_WDONE,
  output logic [1:0]                      AMCI_WRESP,
  output logic                            AMCI_WTIMEOUT,
  // user read side
  input  logic [C_AXI_ADDR_WIDTH-1:0]     AMCI_RADDR,
  input  logic                            AMCI_READ,
  output logic                            AMCI_RIDLE,
  output logic                            AMCI_RDONE,
  output logic [C_AXI_DATA_WIDTH-1:0]     AMCI_RDATA,
  output logic [1:0]                      AMCI_RRESP,
  output logic                            AMCI_RTIMEOUT,
  // AXI write address / data / response
  output logic [C_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic [C_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // AXI read address / data
  output logic [C_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  output logic [2:0]                      M_AXI_ARPROT,
  input  logic [C_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int SW = C_AXI_DATA_WIDTH / 8;

  // ---------------------------------------------------------------- write
  wr_state_t                   r_wstate, w_wstate_nxt;
  logic                        r_awvalid, w_awvalid_nxt;
  logic                        r_wvalid, w_wvalid_nxt;
  logic                        r_bready, w_bready_nxt;
  logic                        r_wdone, w_wdone_nxt;
  logic [1:0]                  r_wresp, w_wresp_nxt;
  logic                        r_wto, w_wto_nxt;
  logic                        w_wlatch;
  logic                        w_wexpired;
  logic [C_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [C_AXI_DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]               r_wstrb;

  // ---------------------------------------------------------------- read
  rd_state_t                   r_rstate, w_rstate_nxt;
  logic                        r_arvalid, w_arvalid_nxt;
  logic                        r_rready, w_rready_nxt;
  logic                        r_rdone, w_rdone_nxt;
  logic [1:0]                  r_rresp, w_rresp_nxt;
  logic [C_AXI_DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic                        r_rto, w_rto_nxt;
  logic                        w_rlatch;
  logic                        w_rexpired;
  logic [C_AXI_ADDR_WIDTH-1:0] r_araddr;

`ifdef AXI_TIMEOUT_EN
  axi_timeout_ctr #(.LIMIT(C_TIMEOUT_CYCLES)) u_wr_timeout (
    .clk       (M_AXI_ACLK),
    .rst       (M_AXI_ARESET),
    .i_clear   (r_wstate == W_IDLE),
    .i_enable  (r_wstate != W_IDLE),
    .o_expired (w_wexpired)
  );

  axi_timeout_ctr #(.LIMIT(C_TIMEOUT_CYCLES)) u_rd_timeout (
    .clk       (M_AXI_ACLK),
    .rst       (M_AXI_ARESET),
    .i_clear   (r_rstate == R_IDLE),
    .i_enable  (r_rstate != R_IDLE),
    .o_expired (w_rexpired)
  );
`else
  assign w_wexpired = 1'b0;
  assign w_rexpired = 1'b0;
`endif

  // ---------------------------------------------------------- write FSM
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_bready_nxt  = r_bready;
    w_wdone_nxt   = 1'b0;
    w_wresp_nxt   = r_wresp;
    w_wto_nxt     = r_wto;
    w_wlatch      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (AMCI_WRITE) begin
          w_wlatch      = 1'b1;
          w_awvalid_nxt = 1'b1;
          w_wvalid_nxt  = 1'b1;
          w_wstate_nxt  = W_ADDR;
        end
      end
      W_ADDR: begin
        // Each VALID retires on its own handshake; move on once both are
        // retired, counting a handshake happening this very cycle.
        w_awvalid_nxt = r_awvalid && !M_AXI_AWREADY;
        w_wvalid_nxt  = r_wvalid && !M_AXI_WREADY;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_bready_nxt = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (M_AXI_BVALID && r_bready) begin
          w_wresp_nxt  = M_AXI_BRESP;
          w_bready_nxt = 1'b0;
          w_wdone_nxt  = 1'b1;
          w_wto_nxt    = 1'b0;
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
    // Timeout abandons the bus transaction outright.
    if (w_wexpired) begin
      w_awvalid_nxt = 1'b0;
      w_wvalid_nxt  = 1'b0;
      w_bready_nxt  = 1'b0;
      w_wdone_nxt   = 1'b1;
      w_wresp_nxt   = RESP_DECERR;
      w_wto_nxt     = 1'b1;
      w_wstate_nxt  = W_IDLE;
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_wstate  <= W_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_wdone   <= 1'b0;
      r_wresp   <= RESP_OKAY;
      r_wto     <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_bready  <= w_bready_nxt;
      r_wdone   <= w_wdone_nxt;
      r_wresp   <= w_wresp_nxt;
      r_wto     <= w_wto_nxt;
      if (w_wlatch) begin
        r_awaddr <= AMCI_WADDR;
        r_wdata  <= AMCI_WDATA;
        r_wstrb  <= AMCI_WSTRB;
      end
    end
  end

  // ----------------------------------------------------------- read FSM
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_arvalid_nxt = r_arvalid;
    w_rready_nxt  = r_rready;
    w_rdone_nxt   = 1'b0;
    w_rresp_nxt   = r_rresp;
    w_rdata_nxt   = r_rdata;
    w_rto_nxt     = r_rto;
    w_rlatch      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (AMCI_READ) begin
          w_rlatch      = 1'b1;
          w_arvalid_nxt = 1'b1;
          w_rstate_nxt  = R_ADDR;
        end
      end
      R_ADDR: begin
        if (M_AXI_ARREADY) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_rstate_nxt  = R_DATA;
        end
      end
      R_DATA: begin
        if (M_AXI_RVALID && r_rready) begin
          w_rdata_nxt  = M_AXI_RDATA;
          w_rresp_nxt  = M_AXI_RRESP;
          w_rready_nxt = 1'b0;
          w_rdone_nxt  = 1'b1;
          w_rto_nxt    = 1'b0;
          w_rstate_nxt = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
    if (w_rexpired) begin
      w_arvalid_nxt = 1'b0;
      w_rready_nxt  = 1'b0;
      w_rdone_nxt   = 1'b1;
      w_rresp_nxt   = RESP_DECERR;
      w_rdata_nxt   = '0;
      w_rto_nxt     = 1'b1;
      w_rstate_nxt  = R_IDLE;
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_rstate  <= R_IDLE;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rdone   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_rto     <= 1'b0;
      r_araddr  <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_rready  <= w_rready_nxt;
      r_rdone   <= w_rdone_nxt;
      r_rresp   <= w_rresp_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rto     <= w_rto_nxt;
      if (w_rlatch) begin
        r_araddr <= AMCI_RADDR;
      end
    end
  end

  // ------------------------------------------------------------ outputs
  assign AMCI_WIDLE    = (r_wstate == W_IDLE) && !AMCI_WRITE;
  assign AMCI_WDONE    = r_wdone;
  assign AMCI_WRESP    = r_wresp;
  assign AMCI_WTIMEOUT = r_wto;

  assign AMCI_RIDLE    = (r_rstate == R_IDLE) && !AMCI_READ;
  assign AMCI_RDONE    = r_rdone;
  assign AMCI_RDATA    = r_rdata;
  assign AMCI_RRESP    = r_rresp;
  assign AMCI_RTIMEOUT = r_rto;

  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_AWPROT  = C_AWPROT;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_ARPROT  = C_ARPROT;
  assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master_ex.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi4_lite_master_ex
// Purpose : Self-checking bench for axi4_lite_master_ex with a configurable
//           AXI4-Lite slave model and a done-pulse scoreboard.
// Options : AXI_TIMEOUT_EN enables the timeout scenario (limit 16 cycles).
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi4_lite_master_ex;

`ifdef AXI_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0;
  logic [3:0]  wstrb = '0;
  logic        wr = 1'b0, rd = 1'b0;
  logic        widle, wdone, wto, ridle, rdone, rto;
  logic [1:0]  wresp, rresp;
  logic [31:0] rdata_o;
  logic [31:0] awaddr, wdata_o, araddr;
  logic [3:0]  wstrb_o;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [2:0]  awprot, arprot;
  logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0]  bresp = 0, rresp_i = 0;
  logic [31:0] rdata_i = 0;

  always #5 clk = ~clk;

  axi4_lite_master_ex #(.C_TIMEOUT_CYCLES(TO_CYC)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .AMCI_WADDR(waddr), .AMCI_WDATA(wdata), .AMCI_WSTRB(wstrb), .AMCI_WRITE(wr),
    .AMCI_WIDLE(widle), .AMCI_WDONE(wdone), .AMCI_WRESP(wresp), .AMCI_WTIMEOUT(wto),
    .AMCI_RADDR(raddr), .AMCI_READ(rd), .AMCI_RIDLE(ridle), .AMCI_RDONE(rdone),
    .AMCI_RDATA(rdata_o), .AMCI_RRESP(rresp), .AMCI_RTIMEOUT(rto),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWPROT(awprot),
    .M_AXI_WDATA(wdata_o), .M_AXI_WSTRB(wstrb_o), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARPROT(arprot),
    .M_AXI_RDATA(rdata_i), .M_AXI_RRESP(rresp_i), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  typedef struct { logic [1:0] resp; logic to; } wexp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; logic to; } rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];

  int total = 0, bad = 0;
  int wdone_cnt = 0, rdone_cnt = 0, aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic [31:0] exp_awaddr = '0, exp_wdata = '0, exp_araddr = '0;
  logic [3:0]  exp_wstrb = '0;
  logic [5:0]  lg [0:63];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ------------------------------------------------------------ slave model
  int  aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  bit  ar_never = 0;
  logic [1:0]  bresp_v = 0, rresp_v = 0;
  logic [31:0] rdata_v = 0;
  int  aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit  aw_got = 0, w_got = 0, b_fire = 0, ar_got = 0, r_fire = 0;

  always @(negedge clk) begin
    if (rst) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; b_fire = 0; ar_got = 0; r_fire = 0;
    end else begin
      // B channel: respond b_delay cycles after both write handshakes
      if (b_fire) begin
        bvalid = 0; aw_got = 0; w_got = 0; b_cnt = 0; b_fire = 0;
      end else if (aw_got && w_got) begin
        if (b_cnt >= b_delay) begin bvalid = 1; bresp = bresp_v; end
        else b_cnt++;
      end
      // R channel: respond r_delay cycles after the AR handshake
      if (r_fire) begin
        rvalid = 0; ar_got = 0; r_cnt = 0; r_fire = 0;
      end else if (ar_got) begin
        if (r_cnt >= r_delay) begin rvalid = 1; rdata_i = rdata_v; rresp_i = rresp_v; end
        else r_cnt++;
      end
      if (awvalid) begin
        if (aw_cnt >= aw_delay) awready = 1; else begin awready = 0; aw_cnt++; end
      end else awready = 0;
      if (wvalid) begin
        if (w_cnt >= w_delay) wready = 1; else begin wready = 0; w_cnt++; end
      end else wready = 0;
      if (arvalid && !ar_never) begin
        if (ar_cnt >= ar_delay) arready = 1; else begin arready = 0; ar_cnt++; end
      end else arready = 0;
      // handshakes that complete on the coming rising edge
      if (awvalid && awready) begin aw_got = 1; aw_hs++; aw_cnt = 0; end
      if (wvalid && wready)   begin w_got = 1;  w_hs++;  w_cnt = 0;  end
      if (arvalid && arready) begin ar_got = 1; ar_hs++; ar_cnt = 0; end
      b_fire = bvalid && bready;
      r_fire = rvalid && rready;
    end
  end

  // ------------------------------------------------------- scoreboard monitor
  always @(negedge clk) begin
    wexp_t we;
    rexp_t re;
    if (wdone === 1'b1) begin
      wdone_cnt++;
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL wdone_unexpected: got pulse expected none");
      end else begin
        we = wq.pop_front();
        chk("wresp", {62'd0, wresp}, {62'd0, we.resp});
        chk("wtimeout", {63'd0, wto}, {63'd0, we.to});
      end
    end
    if (rdone === 1'b1) begin
      rdone_cnt++;
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL rdone_unexpected: got pulse expected none");
      end else begin
        re = rq.pop_front();
        chk("rdata", {32'd0, rdata_o}, {32'd0, re.data});
        chk("rresp", {62'd0, rresp}, {62'd0, re.resp});
        chk("rtimeout", {63'd0, rto}, {63'd0, re.to});
      end
    end
    if (awvalid === 1'b1) chk("awaddr_stable", {32'd0, awaddr}, {32'd0, exp_awaddr});
    if (wvalid === 1'b1) chk("wdata_stable", {28'd0, wstrb_o, wdata_o}, {28'd0, exp_wstrb, exp_wdata});
    if (arvalid === 1'b1) chk("araddr_stable", {32'd0, araddr}, {32'd0, exp_araddr});
  end

  // -------------------------------------------------------------- stimulus
  task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] resp);
    waddr = a; wdata = d; wstrb = s; wr = 1;
    exp_awaddr = a; exp_wdata = d; exp_wstrb = s;
    wq.push_back('{resp: resp, to: 1'b0});
  endtask

  task automatic issue_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                            input logic to);
    raddr = a; rd = 1; exp_araddr = a;
    rq.push_back('{data: d, resp: resp, to: to});
  endtask

  task automatic sample(input int i);
    lg[i] = {widle, awvalid, wvalid, bready, arvalid, rready};
  endtask

  // Waits for a done pulse on the chosen channel, logging per-cycle outputs.
  task automatic wait_done(input bit is_wr, input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit && i < 64; i++) begin
      @(negedge clk);
      if (i == 1) begin wr = 0; rd = 0; end
      sample(i);
      if ((is_wr && wdone) || (!is_wr && rdone)) begin lat = i; break; end
    end
  endtask

  initial begin
    int lat, wl, rl, cnt, aw0, w0, wd0, rd0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", {57'd0, awvalid, wvalid, bready, arvalid, rready, wdone, rdone}, 64'd0);
    chk("reset_status", {32'd0, wresp, rresp, wto, rto, rdata_o[25:0]}, 64'd0);
    chk("reset_rdata", {32'd0, rdata_o}, 64'd0);
    chk("reset_idle", {62'd0, widle, ridle}, 64'd3);
    rst = 0;
    @(negedge clk);

    // 1: always-ready slave, minimum write latency
    issue_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
    wait_done(1, 20, lat);
    chk("w1_latency", lat, 3);
    chk("w1_cycle1", {58'd0, lg[1]}, {58'd0, 6'b011000});
    chk("w1_cycle2", {58'd0, lg[2]}, {58'd0, 6'b000100});
    chk("w1_idle_after", {63'd0, widle}, 64'd1);
    @(negedge clk);

    // 2: W before AW, delayed SLVERR response
    aw_delay = 3; w_delay = 0; b_delay = 5; bresp_v = 2'b10;
    wd0 = wdone_cnt;
    issue_write(32'h14, 32'hA5A5_1234, 4'b0110, 2'b10);
    wait_done(1, 40, lat);
    chk("w2_latency", lat, 11);
    chk("w2_w_first", {58'd0, lg[2]}, {58'd0, 6'b010000});
    chk("w2_bready_start", {58'd0, lg[5]}, {58'd0, 6'b000100});
    cnt = 0;
    for (int i = 1; i < 11; i++) if (lg[i][2]) cnt++;
    chk("w2_bready_cycles", cnt, 6);
    chk("w2_done_cycle", {58'd0, lg[11]}, {58'd0, 6'b100000});
    repeat (3) @(negedge clk);
    chk("w2_one_done", wdone_cnt - wd0, 1);

    // 3: read with delayed ARREADY
    aw_delay = 0; b_delay = 0; ar_delay = 4; r_delay = 0;
    rdata_v = 32'h12345678; rresp_v = 2'b00;
    issue_read(32'h20, 32'h12345678, 2'b00, 1'b0);
    wait_done(0, 40, lat);
    chk("r3_latency", lat, 7);
    chk("r3_rready_start", {58'd0, lg[6]}, {58'd0, 6'b100001});
    chk("r3_ridle_after", {63'd0, ridle}, 64'd1);
    @(negedge clk);
    chk("r3_rdata_hold", {32'd0, rdata_o}, {32'd0, 32'h12345678});

    // 4: concurrent write + read, extra write strobes while busy
    aw_delay = 1; w_delay = 2; b_delay = 1; bresp_v = 2'b01;
    ar_delay = 0; r_delay = 2; rdata_v = 32'hA5A5_0F0F; rresp_v = 2'b10;
    aw0 = aw_hs; w0 = w_hs; wd0 = wdone_cnt; rd0 = rdone_cnt;
    issue_write(32'h30, 32'h0BAD_CAFE, 4'b1001, 2'b01);
    issue_read(32'h34, 32'hA5A5_0F0F, 2'b10, 1'b0);
    wl = -1; rl = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      wr = 0; rd = 0;
      // busy strobe at cycle 2 and in the completion cycle 5
      if (i == 2 || i == 5) begin waddr = 32'h99; wdata = 32'h1111_2222; wr = 1; end
      if (wdone) wl = i;
      if (rdone) rl = i;
    end
    wr = 0;
    chk("c4_wr_latency", wl, 6);
    chk("c4_rd_latency", rl, 5);
    chk("c4_aw_handshakes", aw_hs - aw0, 1);
    chk("c4_w_handshakes", w_hs - w0, 1);
    chk("c4_done_counts", {(wdone_cnt - wd0), (rdone_cnt - rd0)}, {32'd1, 32'd1});
    chk("c4_quiet", {62'd0, awvalid, widle}, 64'd1);

    // 5: reset while in W_RESP and R_DATA
    b_delay = 30; r_delay = 30; aw_delay = 0; w_delay = 0;
    wd0 = wdone_cnt; rd0 = rdone_cnt;
    issue_write(32'h40, 32'h5555_AAAA, 4'hF, 2'b00);
    issue_read(32'h44, 32'h0, 2'b00, 1'b0);
    for (int i = 1; i <= 3; i++) begin @(negedge clk); wr = 0; rd = 0; end
    chk("r5_pre_reset", {62'd0, bready, rready}, 64'd3);
    wq.delete(); rq.delete();
    rst = 1;
    @(negedge clk);
    chk("r5_outs_low", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    chk("r5_no_done", {62'd0, wdone, rdone}, 64'd0);
    chk("r5_idle", {62'd0, widle, ridle}, 64'd3);
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    chk("r5_done_silent", {(wdone_cnt - wd0), (rdone_cnt - rd0)}, 64'd0);

    // 6: recovery after reset, DECERR write and EXOKAY read
    b_delay = 0; r_delay = 0; bresp_v = 2'b11; rdata_v = 32'hCAFEF00D; rresp_v = 2'b01;
    issue_write(32'h44, 32'h0000_00FF, 4'b0001, 2'b11);
    wait_done(1, 20, lat);
    chk("w6_latency", lat, 3);
    issue_read(32'h48, 32'hCAFEF00D, 2'b01, 1'b0);
    wait_done(0, 20, lat);
    chk("r6_latency", lat, 3);
    @(negedge clk);

`ifdef AXI_TIMEOUT_EN
    // 7: slave never accepts AR; read aborts with DECERR
    ar_never = 1;
    issue_read(32'h50, 32'h0, 2'b11, 1'b1);
    wait_done(0, 40, lat);
    chk("t7_latency_window", {63'd0, (lat >= 16 && lat <= 19)}, 64'd1);
    chk("t7_bus_dropped", {62'd0, arvalid, rready}, 64'd0);
    @(negedge clk);
    ar_never = 0; rdata_v = 32'h0BAD_F00D; rresp_v = 2'b00;
    issue_read(32'h54, 32'h0BAD_F00D, 2'b00, 1'b0);
    wait_done(0, 20, lat);
    chk("t7_normal_latency", lat, 3);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("queues_drained", {wq.size(), rq.size()}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
